// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, burst-locked sharing of one memory bus between the I-cache (m0) and D-cache (m1) CMUs.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN (TIMEOUT_CYCLES sets the limit).
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_cs_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    input  logic                  m1_cs_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_GNT0 = 2'd1, S_GNT1 = 2'd2} state_e;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit watchdog counter (1..255)");
    end

    state_e state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   g0, g1;

    assign g0 = state_q == S_GNT0;
    assign g1 = state_q == S_GNT1;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, hit;

    // the granted master has gone TIMEOUT_CYCLES cycles without a memory ack
    assign hit = (g0 || g1) && !mem_ack_i && cnt_q == 8'(TIMEOUT_CYCLES - 1);

    // watchdog count restarts whenever ownership changes or memory acks
    always_comb begin
        cnt_d = (state_q == S_IDLE || state_d != state_q || mem_ack_i) ? 8'd0 : cnt_q + 8'd1;
    end

    // watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_q | hit;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // arbitration: lock while the owner holds cs, hand over directly on release
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            S_IDLE: begin
                if (m0_cs_i && m1_cs_i) state_d = last_gnt_q ? S_GNT0 : S_GNT1;
                else if (m0_cs_i)       state_d = S_GNT0;
                else if (m1_cs_i)       state_d = S_GNT1;
            end
            S_GNT0: begin
                if (!m0_cs_i) begin
                    last_gnt_d = 1'b0;
                    state_d    = m1_cs_i ? S_GNT1 : S_IDLE;
                end
            end
            S_GNT1: begin
                if (!m1_cs_i) begin
                    last_gnt_d = 1'b1;
                    state_d    = m0_cs_i ? S_GNT0 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef MEM_ARB_TIMEOUT_EN
        if (hit) begin
            state_d    = S_IDLE;
            last_gnt_d = g1;
        end
`endif
    end

    // owner state; last_gnt resets to 1 so master 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // bus mux selected by the registered owner; acks only reach the owner
    always_comb begin
        mem_cs_o   = g0 ? m0_cs_i   : g1 ? m1_cs_i   : 1'b0;
        mem_we_o   = g0 ? m0_we_i   : g1 ? m1_we_i   : 1'b0;
        mem_addr_o = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
        mem_data_o = g0 ? m0_data_i : g1 ? m1_data_i : '0;
        m0_ack_o   = g0 & mem_ack_i;
        m1_ack_o   = g1 & mem_ack_i;
        m0_data_o  = mem_data_i;
        m1_data_o  = mem_data_i;
        grant_o    = {g1, g0};
    end

endmodule
